// File: rtl/rv64g_launch_scheduler.sv
// Launch-path issue scheduler: fixed-priority slot grant, register-lock scoreboard, one-deep launch stage.
// Optional macro RV64G_LAUNCH_WB_BYPASS_EN lets same-cycle writeback releases unblock eligibility.

package rv64g_pkg;
    localparam int unsigned NUM_OUTSTANDING = 2;
    localparam int unsigned NUM_REGS        = 32;
endpackage

module rv64g_launch_scheduler #(
    parameter int unsigned NS = rv64g_pkg::NUM_OUTSTANDING + 1,
    parameter int unsigned NR = rv64g_pkg::NUM_REGS,
    parameter int unsigned IW = $clog2(NS)
) (
    input  logic                   clk_i,
    input  logic                   arst_ni,
    input  logic                   clear_i,
    input  logic [NS-1:0]          slot_valid_i,
    output logic [NS-1:0]          slot_ready_o,
    input  logic [NS-1:0]          slot_jump_i,
    input  logic [NS-1:0][NR-1:0]  slot_reg_req_i,
    input  logic [NS-1:0][NR-1:0]  slot_rd_i,
    input  logic [NR-1:0]          wb_release_i,
    output logic [NR-1:0]          locks_o,
    output logic [IW-1:0]          launch_idx_o,
    output logic                   launch_valid_o,
    input  logic                   launch_ready_i
);

    // Register 0 is hardwired and never participates in locking.
    localparam logic [NR-1:0] REG_MASK = ~NR'(1);

    logic [NR-1:0] locks_q;
    logic          out_valid_q;
    logic [IW-1:0] out_idx_q;

    logic [NR-1:0] eff_locks;
    logic          out_free;
    logic [NS-1:0] grant;
    logic [IW-1:0] grant_idx;
    logic [NR-1:0] grant_rd;
    logic          launch;
    logic          older_jump;
    logic [NR-1:0] older_req;
    logic          found;

`ifdef RV64G_LAUNCH_WB_BYPASS_EN
    assign eff_locks = locks_q & ~wb_release_i;
`else
    assign eff_locks = locks_q;
`endif

    assign out_free = ~out_valid_q | launch_ready_i;

    // Oldest-first scan; older valid slots block younger ones on jumps and shared registers.
    always_comb begin
        grant      = '0;
        grant_idx  = '0;
        grant_rd   = '0;
        found      = 1'b0;
        older_jump = 1'b0;
        older_req  = '0;
        for (int i = 0; i < NS; i++) begin
            if (slot_valid_i[i] && !older_jump && !found && out_free && !clear_i
                && ((slot_reg_req_i[i] & eff_locks & REG_MASK) == '0)
                && ((slot_reg_req_i[i] & older_req) == '0)) begin
                grant[i]  = 1'b1;
                grant_idx = IW'(i);
                grant_rd  = slot_rd_i[i];
                found     = 1'b1;
            end
            if (slot_valid_i[i]) begin
                older_jump = older_jump | slot_jump_i[i];
                older_req  = older_req | slot_reg_req_i[i];
            end
        end
    end

    assign launch = |grant;

    // Launch stage and lock scoreboard; a set beats a release on the same bit.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            locks_q     <= '0;
            out_valid_q <= 1'b0;
            out_idx_q   <= '0;
        end else if (clear_i) begin
            locks_q     <= '0;
            out_valid_q <= 1'b0;
        end else if (launch) begin
            locks_q     <= (locks_q & ~wb_release_i) | (grant_rd & REG_MASK);
            out_valid_q <= 1'b1;
            out_idx_q   <= grant_idx;
        end else begin
            locks_q <= locks_q & ~wb_release_i;
            if (launch_ready_i && out_valid_q) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign slot_ready_o   = grant;
    assign locks_o        = locks_q;
    assign launch_idx_o   = out_idx_q;
    assign launch_valid_o = out_valid_q;

endmodule

// File: tb/tb_rv64g_launch_scheduler.sv
// Self-checking bench for rv64g_launch_scheduler: directed slot patterns with a launch-index scoreboard.

module tb_rv64g_launch_scheduler;

    localparam int unsigned NS = rv64g_pkg::NUM_OUTSTANDING + 1;
    localparam int unsigned NR = rv64g_pkg::NUM_REGS;
    localparam int unsigned IW = $clog2(NS);

    logic                  clk_i = 1'b0;
    logic                  arst_ni;
    logic                  clear_i;
    logic [NS-1:0]         slot_valid_i;
    logic [NS-1:0]         slot_ready_o;
    logic [NS-1:0]         slot_jump_i;
    logic [NS-1:0][NR-1:0] slot_reg_req_i;
    logic [NS-1:0][NR-1:0] slot_rd_i;
    logic [NR-1:0]         wb_release_i;
    logic [NR-1:0]         locks_o;
    logic [IW-1:0]         launch_idx_o;
    logic                  launch_valid_o;
    logic                  launch_ready_i;

    int n_tests = 0;
    int n_fail  = 0;
    int sb[$];

    rv64g_launch_scheduler dut (
        .clk_i          (clk_i),
        .arst_ni        (arst_ni),
        .clear_i        (clear_i),
        .slot_valid_i   (slot_valid_i),
        .slot_ready_o   (slot_ready_o),
        .slot_jump_i    (slot_jump_i),
        .slot_reg_req_i (slot_reg_req_i),
        .slot_rd_i      (slot_rd_i),
        .wb_release_i   (wb_release_i),
        .locks_o        (locks_o),
        .launch_idx_o   (launch_idx_o),
        .launch_valid_o (launch_valid_o),
        .launch_ready_i (launch_ready_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NR-1:0] rb(input int n);
        logic [NR-1:0] v;
        v    = '0;
        v[n] = 1'b1;
        return v;
    endfunction

    task automatic idle();
        clear_i        = 1'b0;
        slot_valid_i   = '0;
        slot_jump_i    = '0;
        slot_reg_req_i = '0;
        slot_rd_i      = '0;
        wb_release_i   = '0;
        launch_ready_i = 1'b1;
    endtask

    // Checks one cycle at the falling edge, records granted slots, then steps past the next rising edge.
    task automatic sample_cycle(input string tag, input logic [NS-1:0] exp_ready,
                                input logic exp_valid, input logic [NR-1:0] exp_locks,
                                input int exp_idx);
        @(negedge clk_i);
        check({tag, ":ready"}, 64'(slot_ready_o), 64'(exp_ready));
        check({tag, ":valid"}, 64'(launch_valid_o), 64'(exp_valid));
        check({tag, ":locks"}, 64'(locks_o), 64'(exp_locks));
        if (exp_idx >= 0) check({tag, ":idx"}, 64'(launch_idx_o), 64'(exp_idx));
        for (int i = 0; i < NS; i++) begin
            if (exp_ready[i]) sb.push_back(i);
        end
        @(posedge clk_i);
        #1;
    endtask

    // Every accepted launch must match the oldest recorded grant.
    always @(negedge clk_i) begin
        if (arst_ni && launch_valid_o && launch_ready_i && !clear_i) begin
            check("sb_nonempty", 64'(sb.size() > 0), 64'(1));
            if (sb.size() > 0) check("sb_idx", 64'(launch_idx_o), 64'(sb.pop_front()));
        end
    end

    initial begin
        arst_ni = 1'b0;
        idle();
        repeat (2) @(posedge clk_i);
        #1;
        sample_cycle("reset", '0, 1'b0, '0, 0);
        arst_ni = 1'b1;

        // Basic grant of slot1 over slot2.
        slot_valid_i      = 3'b110;
        slot_reg_req_i[1] = rb(1) | rb(2);
        slot_rd_i[1]      = rb(2);
        slot_reg_req_i[2] = rb(3);
        slot_rd_i[2]      = rb(3);
        sample_cycle("basic_c1", 3'b010, 1'b0, '0, -1);
        idle();
        sample_cycle("basic_c2", 3'b000, 1'b1, rb(2), 1);
        wb_release_i = rb(2);
        sample_cycle("basic_c3", 3'b000, 1'b0, rb(2), -1);
        idle();
        sample_cycle("basic_c4", 3'b000, 1'b0, '0, -1);

        // Older jump blocks younger slot.
        slot_valid_i      = 3'b011;
        slot_jump_i       = 3'b001;
        slot_reg_req_i[0] = rb(4);
        slot_rd_i[0]      = rb(4);
        slot_reg_req_i[1] = rb(6);
        slot_rd_i[1]      = rb(6);
        sample_cycle("jump_c1", 3'b001, 1'b0, '0, -1);
        slot_valid_i = 3'b010;
        slot_jump_i  = '0;
        sample_cycle("jump_c2", 3'b010, 1'b1, rb(4), 0);
        slot_valid_i = '0;
        sample_cycle("jump_c3", 3'b000, 1'b1, rb(4) | rb(6), 1);
        idle();
        wb_release_i = rb(4) | rb(6);
        sample_cycle("jump_c4", 3'b000, 1'b0, rb(4) | rb(6), -1);
        idle();

        // Writeback bypass timing on x5.
        slot_valid_i      = 3'b001;
        slot_reg_req_i[0] = rb(5);
        slot_rd_i[0]      = rb(5);
        sample_cycle("wb_c1", 3'b001, 1'b0, '0, -1);
        idle();
        sample_cycle("wb_c2", 3'b000, 1'b1, rb(5), 0);
        slot_valid_i      = 3'b001;
        slot_reg_req_i[0] = rb(5);
        slot_rd_i[0]      = rb(7);
        wb_release_i      = rb(5);
`ifdef RV64G_LAUNCH_WB_BYPASS_EN
        sample_cycle("wb_c3", 3'b001, 1'b0, rb(5), -1);
        idle();
`else
        sample_cycle("wb_c3", 3'b000, 1'b0, rb(5), -1);
        wb_release_i = '0;
        sample_cycle("wb_c4", 3'b001, 1'b0, '0, -1);
        idle();
`endif
        sample_cycle("wb_c5", 3'b000, 1'b1, rb(7), 0);
        wb_release_i = rb(7);
        sample_cycle("wb_c6", 3'b000, 1'b0, rb(7), -1);
        idle();

        // Locked older slot still orders a younger slot sharing x3; slot2 passes both.
        slot_valid_i      = 3'b001;
        slot_reg_req_i[0] = rb(8);
        slot_rd_i[0]      = rb(8);
        sample_cycle("order_c1", 3'b001, 1'b0, '0, -1);
        slot_valid_i      = 3'b111;
        slot_reg_req_i[0] = rb(3) | rb(8);
        slot_reg_req_i[1] = rb(3) | rb(7);
        slot_rd_i[1]      = rb(7);
        slot_reg_req_i[2] = rb(10);
        slot_rd_i[2]      = rb(10);
        sample_cycle("order_c2", 3'b100, 1'b1, rb(8), 0);
        slot_valid_i = 3'b011;
        sample_cycle("order_c3", 3'b000, 1'b1, rb(8) | rb(10), 2);
        idle();
        wb_release_i = rb(8) | rb(10);
        sample_cycle("order_c4", 3'b000, 1'b0, rb(8) | rb(10), -1);
        idle();
        sample_cycle("order_c5", 3'b000, 1'b0, '0, -1);

        // Back-to-back launches at full throughput.
        slot_valid_i = 3'b111;
        for (int i = 0; i < 3; i++) begin
            slot_reg_req_i[i] = rb(14 + i);
            slot_rd_i[i]      = rb(14 + i);
        end
        sample_cycle("b2b_c1", 3'b001, 1'b0, '0, -1);
        slot_valid_i = 3'b110;
        sample_cycle("b2b_c2", 3'b010, 1'b1, rb(14), 0);
        slot_valid_i = 3'b100;
        sample_cycle("b2b_c3", 3'b100, 1'b1, rb(14) | rb(15), 1);
        idle();
        sample_cycle("b2b_c4", 3'b000, 1'b1, rb(14) | rb(15) | rb(16), 2);
        wb_release_i = rb(14) | rb(15) | rb(16);
        sample_cycle("b2b_c5", 3'b000, 1'b0, rb(14) | rb(15) | rb(16), -1);
        idle();

        // Stalled output stage holds its index and blocks grants.
        slot_valid_i      = 3'b001;
        slot_reg_req_i[0] = rb(11);
        slot_rd_i[0]      = rb(11);
        launch_ready_i    = 1'b0;
        sample_cycle("stall_c1", 3'b001, 1'b0, '0, -1);
        slot_valid_i      = 3'b010;
        slot_reg_req_i[1] = rb(12);
        slot_rd_i[1]      = rb(12);
        for (int c = 0; c < 3; c++) sample_cycle("stall_hold", 3'b000, 1'b1, rb(11), 0);
        launch_ready_i = 1'b1;
        sample_cycle("stall_drain", 3'b010, 1'b1, rb(11), 0);
        idle();
        sample_cycle("stall_c6", 3'b000, 1'b1, rb(11) | rb(12), 1);
        wb_release_i = rb(11) | rb(12);
        sample_cycle("stall_c7", 3'b000, 1'b0, rb(11) | rb(12), -1);
        idle();
        check("sb_drained", 64'(sb.size()), 64'(0));

        // Flush after a slot2 launch.
        slot_valid_i      = 3'b100;
        slot_reg_req_i[2] = rb(9);
        slot_rd_i[2]      = rb(9);
        sample_cycle("clear_c1", 3'b100, 1'b0, '0, -1);
        clear_i        = 1'b1;
        launch_ready_i = 1'b0;
        wb_release_i   = rb(9);
        sample_cycle("clear_c2", 3'b000, 1'b1, rb(9), 2);
        idle();
        sb.delete();
        sample_cycle("clear_c3", 3'b000, 1'b0, '0, -1);

        // Destination x0 never locks.
        slot_valid_i      = 3'b001;
        slot_reg_req_i[0] = rb(0);
        slot_rd_i[0]      = rb(0);
        sample_cycle("x0_c1", 3'b001, 1'b0, '0, -1);
        idle();
        sample_cycle("x0_c2", 3'b000, 1'b1, '0, 0);
        sample_cycle("x0_c3", 3'b000, 1'b0, '0, -1);
        check("sb_final", 64'(sb.size()), 64'(0));

        // Asynchronous reset mid-operation.
        slot_valid_i      = 3'b001;
        slot_reg_req_i[0] = rb(20);
        slot_rd_i[0]      = rb(20);
        launch_ready_i    = 1'b0;
        sample_cycle("arst_c1", 3'b001, 1'b0, '0, -1);
        idle();
        #1;
        check("arst_pre_valid", 64'(launch_valid_o), 64'(1));
        arst_ni = 1'b0;
        #1;
        check("arst_valid", 64'(launch_valid_o), 64'(0));
        check("arst_locks", 64'(locks_o), 64'(0));
        check("arst_idx", 64'(launch_idx_o), 64'(0));
        sb.delete();
        @(posedge clk_i);
        #1;
        arst_ni = 1'b1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
